// File: rtl/memory_pipe_pkg.sv
// Shared defaults and response record for memory_pipe.
// The optional error flag is enabled by defining MEMORY_PIPE_ERR_EN.
package memory_pipe_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_DEPTH       = 1024;
    localparam int DEF_LATENCY     = 2;
    localparam int DEF_OUTSTANDING = 4;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  err;
    } resp_t;

    // Index width that stays legal for a single-entry storage array.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memory_pipe_fifo.sv
// Synchronous FIFO holding completed responses until the consumer takes them.
// Storage is not reset; only the pointers and occupancy are.
module memory_pipe_fifo
    import memory_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W,
    parameter int DEPTH = DEF_OUTSTANDING
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid
);

    localparam int PW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid   = (count != '0);
    assign do_pop  = pop && valid;
    assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
    assign head    = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/memory_pipe.sv
// Pipelined word memory with fixed-latency responses, credit flow control and a response FIFO.
// Define MEMORY_PIPE_ERR_EN to report out-of-range accesses on mem_err_o.
module memory_pipe
    import memory_pipe_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int LATENCY     = DEF_LATENCY,
    parameter int OUTSTANDING = DEF_OUTSTANDING
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_req_valid_i,
    output logic                mem_req_ready_o,
    input  logic [31:0]         mem_addr_i,
    input  logic                mem_we_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic [DATA_W/8-1:0] mem_be_i,
    output logic                mem_resp_valid_o,
    input  logic                mem_resp_ready_i,
    output logic [DATA_W-1:0]   mem_data_o,
    output logic                mem_err_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int SHIFT = $clog2(BE_W);
    localparam int AW    = clog2_min1(DEPTH);
    localparam int CW    = $clog2(OUTSTANDING) + 1;
`ifdef MEMORY_PIPE_ERR_EN
    localparam int RESP_W = DATA_W + 1;
`else
    localparam int RESP_W = DATA_W;
`endif

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CW-1:0]     credit;
    logic              accept;
    logic              pop;
    logic              fifo_valid;
    logic [31:0]       word_idx;
    logic              in_range;
    logic [AW-1:0]     mem_idx;
    logic [DATA_W-1:0] rd_word;
    logic              vld_p0;
    logic [RESP_W-1:0] resp_p0;
    logic              push;
    logic [RESP_W-1:0] push_data;
    logic [RESP_W-1:0] head;

    assign mem_req_ready_o = (credit < CW'(OUTSTANDING));
    assign accept          = mem_req_valid_i && mem_req_ready_o;
    assign word_idx        = mem_addr_i >> SHIFT;
    assign in_range        = (word_idx < 32'(DEPTH));
    assign mem_idx         = word_idx[AW-1:0];

    // Stage p0: accept cycle, array written and read here
    always_ff @(posedge clk) begin
        if (accept && mem_we_i && in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_be_i[b]) mem[mem_idx][b*8 +: 8] <= mem_wdata_i[b*8 +: 8];
            end
        end
    end

    assign rd_word = (in_range && !mem_we_i) ? mem[mem_idx] : '0;
    assign vld_p0  = accept;
`ifdef MEMORY_PIPE_ERR_EN
    assign resp_p0 = {!in_range, rd_word};
`else
    assign resp_p0 = rd_word;
`endif

    // Stage p1: LATENCY-1 delay registers ahead of the response FIFO
    generate
        if (LATENCY == 1) begin : g_direct
            assign push      = vld_p0;
            assign push_data = resp_p0;
        end else begin : g_delay
            logic [RESP_W-1:0]  resp_p1 [LATENCY-1];
            logic [LATENCY-2:0] vld_p1;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p1 <= '0;
                end else begin
                    vld_p1[0] <= vld_p0;
                    for (int s = 1; s < LATENCY - 1; s++) vld_p1[s] <= vld_p1[s-1];
                end
            end

            always_ff @(posedge clk) begin
                resp_p1[0] <= resp_p0;
                for (int s = 1; s < LATENCY - 1; s++) resp_p1[s] <= resp_p1[s-1];
            end

            assign push      = vld_p1[LATENCY-2];
            assign push_data = resp_p1[LATENCY-2];
        end
    endgenerate

    memory_pipe_fifo #(
        .WIDTH (RESP_W),
        .DEPTH (OUTSTANDING)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .valid     (fifo_valid)
    );

    // Stage p2: FIFO head; outputs forced quiet while reset is held
    assign mem_resp_valid_o = fifo_valid && !rst;
    assign pop              = mem_resp_valid_o && mem_resp_ready_i;
    assign mem_data_o       = mem_resp_valid_o ? head[DATA_W-1:0] : '0;
`ifdef MEMORY_PIPE_ERR_EN
    assign mem_err_o = mem_resp_valid_o && head[DATA_W];
`else
    assign mem_err_o = 1'b0;
`endif

    // Credits cover requests in the delay line plus those waiting in the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            credit <= '0;
        end else if (accept && !pop) begin
            credit <= credit + 1'b1;
        end else if (!accept && pop) begin
            credit <= credit - 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_pipe.sv
// Scoreboard bench for memory_pipe at default parameters; honours MEMORY_PIPE_ERR_EN.
`timescale 1ns/1ps
module tb_memory_pipe;
    import memory_pipe_pkg::*;

    localparam int DW    = DEF_DATA_W;
    localparam int DEPTH = DEF_DEPTH;
    localparam int LAT   = DEF_LATENCY;
    localparam int OUTS  = DEF_OUTSTANDING;
`ifdef MEMORY_PIPE_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    typedef struct {
        resp_t r;
        int    cyc;
    } sb_t;

    typedef struct packed {
        logic          we;
        logic [31:0]   addr;
        logic [DW-1:0] wd;
        logic [3:0]    be;
    } req_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_req_valid_i;
    logic          mem_req_ready_o;
    logic [31:0]   mem_addr_i;
    logic          mem_we_i;
    logic [DW-1:0] mem_wdata_i;
    logic [3:0]    mem_be_i;
    logic          mem_resp_valid_o;
    logic          mem_resp_ready_i;
    logic [DW-1:0] mem_data_o;
    logic          mem_err_o;

    sb_t           sb[$];
    req_t          req_q[$];
    logic [DW-1:0] got_d[$];
    logic          got_e[$];
    int            got_lat[$];
    logic [DW-1:0] exp_d[$];
    logic [DW-1:0] model [int];
    int            cycle;
    int            checks;
    int            errors;

    always #5 clk = ~clk;

    memory_pipe #(
        .DATA_W      (DW),
        .DEPTH       (DEPTH),
        .LATENCY     (LAT),
        .OUTSTANDING (OUTS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_req_valid_i  (mem_req_valid_i),
        .mem_req_ready_o  (mem_req_ready_o),
        .mem_addr_i       (mem_addr_i),
        .mem_we_i         (mem_we_i),
        .mem_wdata_i      (mem_wdata_i),
        .mem_be_i         (mem_be_i),
        .mem_resp_valid_o (mem_resp_valid_o),
        .mem_resp_ready_i (mem_resp_ready_i),
        .mem_data_o       (mem_data_o),
        .mem_err_o        (mem_err_o)
    );

    function automatic req_t rd(input logic [31:0] a);
        req_t q;
        q = '0;
        q.addr = a;
        return q;
    endfunction

    function automatic req_t wr(input logic [31:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        req_t q;
        q.we = 1'b1; q.addr = a; q.wd = d; q.be = be;
        return q;
    endfunction

    // One clock: drive, sample before the edge, push expectation on accept, pop on response.
    task automatic pump(input bit v, input req_t rq, input bit rr,
                        output bit acc, output bit vo, output bit popped,
                        output logic [DW-1:0] d, output logic e,
                        output sb_t x, output bit und, output int pcyc);
        sb_t           n;
        logic [31:0]   idx;
        logic [DW-1:0] w;
        mem_req_valid_i  = v;
        mem_addr_i       = rq.addr;
        mem_we_i         = rq.we;
        mem_wdata_i      = rq.wd;
        mem_be_i         = rq.be;
        mem_resp_ready_i = rr;
        #1;
        acc    = v && mem_req_ready_o;
        vo     = mem_resp_valid_o;
        popped = mem_resp_valid_o && rr;
        d      = mem_data_o;
        e      = mem_err_o;
        pcyc   = cycle;
        und    = 1'b0;
        x.r    = '0;
        x.cyc  = 0;
        if (popped) begin
            if (sb.size() == 0) und = 1'b1;
            else x = sb.pop_front();
        end
        if (acc) begin
            idx     = rq.addr >> 2;
            n.cyc   = cycle;
            n.r     = '0;
            if (idx >= DEPTH) begin
                n.r.err = ERR_ON;
            end else if (rq.we) begin
                w = model.exists(int'(idx)) ? model[int'(idx)] : '0;
                for (int b = 0; b < 4; b++) if (rq.be[b]) w[b*8 +: 8] = rq.wd[b*8 +: 8];
                model[int'(idx)] = w;
            end else begin
                n.r.data = model.exists(int'(idx)) ? model[int'(idx)] : 'x;
            end
            sb.push_back(n);
        end
        @(posedge clk);
        cycle++;
        @(negedge clk);
    endtask

    // Streams req_q with valid held high and the consumer always ready.
    task automatic run_list(input int budget, output bit timeout, output int missed);
        bit acc, vo, pp, und;
        logic [DW-1:0] d;
        logic e;
        sb_t x;
        int pc, i, n;
        got_d.delete(); got_e.delete(); got_lat.delete(); exp_d.delete();
        i = 0; n = req_q.size(); missed = 0;
        while ((i < n || sb.size() > 0) && budget > 0) begin
            budget--;
            if (i < n) pump(1'b1, req_q[i], 1'b1, acc, vo, pp, d, e, x, und, pc);
            else       pump(1'b0, '0, 1'b1, acc, vo, pp, d, e, x, und, pc);
            if (i < n && !acc) missed++;
            if (acc) i++;
            if (pp) begin
                got_d.push_back(d);
                got_e.push_back(e);
                got_lat.push_back(und ? -1 : pc - x.cyc);
                exp_d.push_back(und ? 'x : x.r.data);
            end
        end
        timeout = (i < n || sb.size() > 0);
        req_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_req_valid_i = 1'b0; mem_addr_i = '0; mem_we_i = 1'b0;
        mem_wdata_i = '0; mem_be_i = '0; mem_resp_ready_i = 1'b1;
        repeat (2) begin
            #1;
            checks++;
            if (mem_resp_valid_o !== 1'b0 || mem_data_o !== '0 || mem_err_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: valid=%b data=%h err=%b, required 0/0/0",
                         mem_resp_valid_o, mem_data_o, mem_err_o);
            end
            @(posedge clk); @(negedge clk);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b, required 1", mem_req_ready_o);
        end
        checks++;
        if (mem_resp_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b, required 0", mem_resp_valid_o);
        end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [DW-1:0] want [4];
        bit to; int missed;
        want = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEAA};
        req_q.push_back(wr(400, 32'hDEADBEEF, 4'hF));
        req_q.push_back(rd(400));
        req_q.push_back(wr(400, 32'h000000AA, 4'h1));
        req_q.push_back(rd(400));
        run_list(60, to, missed);
        checks++;
        if (to || got_d.size() != 4) begin
            errors++; $display("FAIL wr_rd_count: got %0d responses (timeout=%0b), required 4", got_d.size(), to);
        end
        for (int k = 0; k < got_d.size() && k < 4; k++) begin
            checks++;
            if (got_d[k] !== want[k] || got_e[k] !== 1'b0 || got_lat[k] != LAT) begin
                errors++;
                $display("FAIL wr_rd_resp%0d: data=%h err=%b lat=%0d, required %h/0/%0d",
                         k, got_d[k], got_e[k], got_lat[k], want[k], LAT);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] want_d [7];
        logic          want_e [7];
        bit to; int missed;
        want_d = '{32'h0, 32'h0, 32'h0, 32'h11111111, 32'h22222222, 32'h0, 32'h0};
        want_e = '{1'b0, 1'b0, ERR_ON, 1'b0, 1'b0, ERR_ON, ERR_ON};
        req_q.push_back(wr(0,    32'h11111111, 4'hF));
        req_q.push_back(wr(4092, 32'h22222222, 4'hF));
        req_q.push_back(wr(4096, 32'hFFFFFFFF, 4'hF));
        req_q.push_back(rd(0));
        req_q.push_back(rd(4092));
        req_q.push_back(rd(8000));
        req_q.push_back(rd(4096));
        run_list(60, to, missed);
        checks++;
        if (to || got_d.size() != 7) begin
            errors++; $display("FAIL oor_count: got %0d responses (timeout=%0b), required 7", got_d.size(), to);
        end
        for (int k = 0; k < got_d.size() && k < 7; k++) begin
            checks++;
            if (got_d[k] !== want_d[k] || got_e[k] !== want_e[k]) begin
                errors++;
                $display("FAIL oor_resp%0d: data=%h err=%b, required %h/%b",
                         k, got_d[k], got_e[k], want_d[k], want_e[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to; int missed;
        for (int k = 0; k < 16; k++) req_q.push_back(wr(k * 4, 32'hA5000000 + k * 32'h01010101, 4'hF));
        run_list(80, to, missed);
        checks++;
        if (to || got_d.size() != 16) begin
            errors++; $display("FAIL b2b_preload: got %0d responses (timeout=%0b), required 16", got_d.size(), to);
        end
        for (int k = 0; k < 16; k++) req_q.push_back(rd(k * 4));
        run_list(80, to, missed);
        checks++;
        if (to || got_d.size() != 16 || missed != 0) begin
            errors++;
            $display("FAIL b2b_stream: responses=%0d stalls=%0d timeout=%0b, required 16/0/0", got_d.size(), missed, to);
        end
        for (int k = 0; k < got_d.size(); k++) begin
            checks++;
            if (got_d[k] !== 32'hA5000000 + k * 32'h01010101 || got_d[k] !== exp_d[k] || got_lat[k] != LAT) begin
                errors++;
                $display("FAIL b2b_resp%0d: data=%h lat=%0d, required %h/%0d",
                         k, got_d[k], got_lat[k], 32'hA5000000 + k * 32'h01010101, LAT);
            end
        end
    endtask

    task automatic test_backpressure();
        bit acc, vo, pp, und;
        logic [DW-1:0] d, held;
        logic e;
        sb_t x;
        int pc, accepted, pops, budget, unstable;
        bit have_held;
        accepted = 0; pops = 0; unstable = 0; have_held = 1'b0; held = '0;
        for (int c = 0; c < 10; c++) begin
            pump(accepted < 6, rd(accepted * 4), 1'b0, acc, vo, pp, d, e, x, und, pc);
            if (acc) accepted++;
            if (vo) begin
                if (!have_held) begin held = d; have_held = 1'b1; end
                else if (d !== held) unstable++;
            end
        end
        checks++;
        if (accepted != OUTS) begin
            errors++; $display("FAIL bp_accepted: got %0d, required %0d", accepted, OUTS);
        end
        checks++;
        if (mem_req_ready_o !== 1'b0) begin
            errors++; $display("FAIL bp_ready_low: got %b, required 0", mem_req_ready_o);
        end
        checks++;
        if (!have_held || unstable != 0) begin
            errors++; $display("FAIL bp_hold_stable: changes=%0d seen=%0b, required 0/1", unstable, have_held);
        end
        budget = 40;
        while ((accepted < 6 || sb.size() > 0) && budget > 0) begin
            budget--;
            pump(accepted < 6, rd(accepted * 4), 1'b1, acc, vo, pp, d, e, x, und, pc);
            if (acc) begin
                checks++;
                if (pops == 0) begin
                    errors++; $display("FAIL bp_accept_order: accept #%0d before any pop, required after", accepted + 1);
                end
                accepted++;
            end
            if (pp) begin
                checks++;
                if (und || d !== x.r.data || d !== 32'hA5000000 + pops * 32'h01010101) begin
                    errors++;
                    $display("FAIL bp_resp%0d: data=%h, required %h", pops, d, 32'hA5000000 + pops * 32'h01010101);
                end
                pops++;
            end
        end
        checks++;
        if (pops != 6) begin
            errors++; $display("FAIL bp_total: got %0d responses, required 6", pops);
        end
    endtask

    task automatic test_reset_midway();
        bit acc, vo, pp, und;
        logic [DW-1:0] d;
        logic e;
        sb_t x;
        int pc, accepted, seen, budget;
        accepted = 0; seen = 0;
        for (int c = 0; c < 6 && accepted < 3; c++) begin
            pump(1'b1, rd(accepted * 4), 1'b0, acc, vo, pp, d, e, x, und, pc);
            if (acc) accepted++;
        end
        rst = 1'b1;
        repeat (2) begin
            pump(1'b0, '0, 1'b1, acc, vo, pp, d, e, x, und, pc);
            if (vo) seen++;
        end
        rst = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (mem_req_ready_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_ready: got %b, required 1", mem_req_ready_o);
        end
        @(negedge clk);
        repeat (LAT + 4) begin
            pump(1'b0, '0, 1'b1, acc, vo, pp, d, e, x, und, pc);
            if (vo) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL rstmid_flush: got %0d stale responses, required 0", seen);
        end
        accepted = 0;
        for (int c = 0; c < 8; c++) begin
            pump(1'b1, rd(accepted * 4), 1'b0, acc, vo, pp, d, e, x, und, pc);
            if (acc) accepted++;
        end
        checks++;
        if (accepted != OUTS) begin
            errors++; $display("FAIL rstmid_credit: accepted %0d after reset, required %0d", accepted, OUTS);
        end
        budget = 20; seen = 0;
        while (sb.size() > 0 && budget > 0) begin
            budget--;
            pump(1'b0, '0, 1'b1, acc, vo, pp, d, e, x, und, pc);
            if (pp) begin
                checks++;
                if (und || d !== x.r.data) begin
                    errors++; $display("FAIL rstmid_resp%0d: data=%h, required %h", seen, d, x.r.data);
                end
                seen++;
            end
        end
        checks++;
        if (seen != OUTS) begin
            errors++; $display("FAIL rstmid_drain: got %0d responses, required %0d", seen, OUTS);
        end
    endtask

    initial begin
        cycle = 0; checks = 0; errors = 0;
        test_reset();
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_backpressure();
        test_reset_midway();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
